// File: rtl/lbus_tx_rdy_buffer_pkg.sv
// Shared LBUS definitions: segment geometry and the per-segment record that LBUS words are built from.
// No logic, so there is no latency or backpressure here.
package lbus_tx_rdy_buffer_pkg;

    localparam int LBUS_SEG_W        = 128;
    localparam int LBUS_MTY_W        = 4;
    localparam int LBUS_DEF_SEGMENTS = 4;

    // One segment lane of an LBUS word. A full word is a packed array of these, lane 0 in the low bits.
    typedef struct packed {
        logic [LBUS_SEG_W-1:0] data;
        logic                  ena;
        logic                  sop;
        logic                  eop;
        logic [LBUS_MTY_W-1:0] mty;
    } lbus_seg_t;

    localparam int LBUS_SEG_BITS = $bits(lbus_seg_t);

    typedef lbus_seg_t [LBUS_DEF_SEGMENTS-1:0] lbus_word_t;

endpackage

// File: rtl/lbus_tx_rdy_buffer_if.sv
// LBUS RX/TX bundle around the TX ready buffer. The master modport is the side that sources RX words and TX_RDY.
// Pure wiring: no latency, and no backpressure of its own.
interface lbus_tx_rdy_buffer_if
    import lbus_tx_rdy_buffer_pkg::*;
#(
    parameter int SEGMENTS = 4
);
    logic [SEGMENTS*LBUS_SEG_W-1:0] RX_DATA;
    logic [SEGMENTS-1:0]            RX_ENA;
    logic [SEGMENTS-1:0]            RX_SOP;
    logic [SEGMENTS-1:0]            RX_EOP;
    logic [SEGMENTS*LBUS_MTY_W-1:0] RX_MTY;
    logic                           RX_SRC_RDY;
    logic                           RX_DST_RDY;
    logic [SEGMENTS*LBUS_SEG_W-1:0] TX_DATA;
    logic [SEGMENTS-1:0]            TX_ENA;
    logic [SEGMENTS-1:0]            TX_SOP;
    logic [SEGMENTS-1:0]            TX_EOP;
    logic [SEGMENTS*LBUS_MTY_W-1:0] TX_MTY;
    logic                           TX_RDY;
    logic                           FIFO_EMPTY;

    modport master (
        output RX_DATA, RX_ENA, RX_SOP, RX_EOP, RX_MTY, RX_SRC_RDY, TX_RDY,
        input  RX_DST_RDY, TX_DATA, TX_ENA, TX_SOP, TX_EOP, TX_MTY, FIFO_EMPTY
    );

    modport slave (
        input  RX_DATA, RX_ENA, RX_SOP, RX_EOP, RX_MTY, RX_SRC_RDY, TX_RDY,
        output RX_DST_RDY, TX_DATA, TX_ENA, TX_SOP, TX_EOP, TX_MTY, FIFO_EMPTY
    );

endinterface

// File: rtl/lbus_fifo_ram.sv
// Register-array word store with one synchronous write port and one asynchronous read port.
// Writes take effect on the clock edge, reads are combinational, and it has no flow control of its own.
module lbus_fifo_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    // Storage has no reset: the pointers and count in the controller decide which entries are live.
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/lbus_tx_rdy_buffer.sv
// Buffers LBUS words ahead of a CMAC TX port whose TX_RDY is seen through RDY_REGS flops.
// A word reaches TX one edge after it is written. RX_DST_RDY is a registered (count < DEPTH).
module lbus_tx_rdy_buffer
    import lbus_tx_rdy_buffer_pkg::*;
#(
    parameter int SEGMENTS = 4,
    parameter int DEPTH    = 8,
    parameter int RDY_REGS = 1
) (
    input  logic                 CMAC_CLK,
    input  logic                 CMAC_RESET,
    lbus_tx_rdy_buffer_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = SEGMENTS * LBUS_SEG_BITS;
    localparam int DW = SEGMENTS * LBUS_SEG_W;
    localparam int MW = SEGMENTS * LBUS_MTY_W;

    lbus_seg_t [SEGMENTS-1:0] w_wr_word;
    lbus_seg_t [SEGMENTS-1:0] w_rd_word;
    logic [WW-1:0]            w_rd_bits;

    logic [RDY_REGS-1:0] r_rdy_pipe;
    logic                w_rdy_d;
    logic                w_push;
    logic                w_pop;
    logic [AW-1:0]       r_wptr;
    logic [AW-1:0]       r_rptr;
    logic [CW-1:0]       r_count;
    logic [CW-1:0]       w_count_nxt;
    logic                r_dst_rdy;
    logic                r_empty;

    logic [DW-1:0]       r_tx_data;
    logic [SEGMENTS-1:0] r_tx_ena;
    logic [SEGMENTS-1:0] r_tx_sop;
    logic [SEGMENTS-1:0] r_tx_eop;
    logic [MW-1:0]       r_tx_mty;

    always_comb begin
        w_wr_word = '0;
        for (int s = 0; s < SEGMENTS; s++) begin
            w_wr_word[s].data = bus.RX_DATA[s*LBUS_SEG_W +: LBUS_SEG_W];
            w_wr_word[s].ena  = bus.RX_ENA[s];
            w_wr_word[s].sop  = bus.RX_SOP[s];
            w_wr_word[s].eop  = bus.RX_EOP[s];
            w_wr_word[s].mty  = bus.RX_MTY[s*LBUS_MTY_W +: LBUS_MTY_W];
        end
    end

    assign w_rd_word = w_rd_bits;
    assign w_rdy_d   = r_rdy_pipe[RDY_REGS-1];

    // Handshakes with RX_ENA all clear are accepted but never written, so they are dropped here.
    assign w_push      = bus.RX_SRC_RDY & r_dst_rdy & (|bus.RX_ENA);
    assign w_pop       = w_rdy_d & (r_count != '0);
    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

    lbus_fifo_ram #(
        .WIDTH (WW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .i_clk   (CMAC_CLK),
        .i_we    (w_push),
        .i_waddr (r_wptr),
        .i_wdata (w_wr_word),
        .i_raddr (r_rptr),
        .o_rdata (w_rd_bits)
    );

    always_ff @(posedge CMAC_CLK or posedge CMAC_RESET) begin
        if (CMAC_RESET) begin
            r_rdy_pipe <= '0;
        end else begin
            r_rdy_pipe[0] <= bus.TX_RDY;
            for (int i = 1; i < RDY_REGS; i++) begin
                r_rdy_pipe[i] <= r_rdy_pipe[i-1];
            end
        end
    end

    always_ff @(posedge CMAC_CLK or posedge CMAC_RESET) begin
        if (CMAC_RESET) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_dst_rdy <= 1'b0;
            r_empty   <= 1'b1;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_count   <= w_count_nxt;
            r_dst_rdy <= (w_count_nxt < CW'(DEPTH));
            r_empty   <= (w_count_nxt == '0);
        end
    end

    // Without a pop the flags go idle, and data/mty hold their old value so the wide bus does not toggle.
    always_ff @(posedge CMAC_CLK or posedge CMAC_RESET) begin
        if (CMAC_RESET) begin
            r_tx_data <= '0;
            r_tx_ena  <= '0;
            r_tx_sop  <= '0;
            r_tx_eop  <= '0;
            r_tx_mty  <= '0;
        end else if (w_pop) begin
            for (int s = 0; s < SEGMENTS; s++) begin
                r_tx_data[s*LBUS_SEG_W +: LBUS_SEG_W] <= w_rd_word[s].data;
                r_tx_ena[s]                           <= w_rd_word[s].ena;
                r_tx_sop[s]                           <= w_rd_word[s].sop;
                r_tx_eop[s]                           <= w_rd_word[s].eop;
                r_tx_mty[s*LBUS_MTY_W +: LBUS_MTY_W]  <= w_rd_word[s].mty;
            end
        end else begin
            r_tx_ena <= '0;
            r_tx_sop <= '0;
            r_tx_eop <= '0;
        end
    end

    assign bus.RX_DST_RDY = r_dst_rdy;
    assign bus.FIFO_EMPTY = r_empty;
    assign bus.TX_DATA    = r_tx_data;
    assign bus.TX_ENA     = r_tx_ena;
    assign bus.TX_SOP     = r_tx_sop;
    assign bus.TX_EOP     = r_tx_eop;
    assign bus.TX_MTY     = r_tx_mty;

endmodule

// File: tb/tb_lbus_tx_rdy_buffer.sv
// Directed bench for lbus_tx_rdy_buffer with SEGMENTS=4, DEPTH=8 and RDY_REGS=2.
// Inputs are driven 1ns after each rising edge, and outputs are sampled at that same point.
module tb_lbus_tx_rdy_buffer;

    localparam int SEG = 4;
    localparam int DEP = 8;
    localparam int RR  = 2;
    localparam int DW  = SEG * 128;
    localparam int MW  = SEG * 4;

    logic CMAC_CLK   = 1'b0;
    logic CMAC_RESET = 1'b1;

    lbus_tx_rdy_buffer_if #(.SEGMENTS(SEG)) bus ();

    lbus_tx_rdy_buffer #(
        .SEGMENTS (SEG),
        .DEPTH    (DEP),
        .RDY_REGS (RR)
    ) dut (
        .CMAC_CLK   (CMAC_CLK),
        .CMAC_RESET (CMAC_RESET),
        .bus        (bus)
    );

    always #5 CMAC_CLK = ~CMAC_CLK;

    typedef struct {
        logic [DW-1:0]  data;
        logic [SEG-1:0] ena;
        logic [SEG-1:0] sop;
        logic [SEG-1:0] eop;
        logic [MW-1:0]  mty;
    } word_t;

    word_t obs_q[$];
    word_t exp_q[$];
    int    errors = 0;
    int    checks = 0;

    function automatic logic [DW-1:0] make_data(input logic [31:0] tag);
        logic [DW-1:0] d;
        for (int i = 0; i < DW/32; i++) begin
            d[i*32 +: 32] = tag ^ (32'h0101_0101 * 32'(i));
        end
        return d;
    endfunction

    always @(posedge CMAC_CLK) begin
        #1;
        if (bus.TX_ENA != '0) begin
            obs_q.push_back('{bus.TX_DATA, bus.TX_ENA, bus.TX_SOP, bus.TX_EOP, bus.TX_MTY});
        end
    end

    task automatic tick();
        @(posedge CMAC_CLK);
        #1;
    endtask

    task automatic idle(input int n);
        bus.RX_SRC_RDY = 1'b0;
        bus.RX_ENA     = '0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic offer(input logic [31:0] tag, input logic [SEG-1:0] ena, input logic [SEG-1:0] sop,
                         input logic [SEG-1:0] eop, input logic [MW-1:0] mty, output logic acc);
        word_t w;
        w.data = make_data(tag);
        w.ena  = ena;
        w.sop  = sop;
        w.eop  = eop;
        w.mty  = mty;
        bus.RX_DATA    = w.data;
        bus.RX_ENA     = ena;
        bus.RX_SOP     = sop;
        bus.RX_EOP     = eop;
        bus.RX_MTY     = mty;
        bus.RX_SRC_RDY = 1'b1;
        acc = bus.RX_DST_RDY;
        if (acc && ena != '0) exp_q.push_back(w);
        tick();
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++; if (bus.TX_ENA !== '0 || bus.TX_SOP !== '0 || bus.TX_EOP !== '0) begin errors++;
            $display("FAIL reset_flags: ena=%h sop=%h eop=%h, want 0", bus.TX_ENA, bus.TX_SOP, bus.TX_EOP); end
        checks++; if (bus.TX_DATA !== '0 || bus.TX_MTY !== '0) begin errors++;
            $display("FAIL reset_data: data[31:0]=%h mty=%h, want 0", bus.TX_DATA[31:0], bus.TX_MTY); end
        checks++; if (bus.RX_DST_RDY !== 1'b0) begin errors++;
            $display("FAIL reset_dst_rdy: got %b want 0", bus.RX_DST_RDY); end
        checks++; if (bus.FIFO_EMPTY !== 1'b1) begin errors++;
            $display("FAIL reset_empty: got %b want 1", bus.FIFO_EMPTY); end
        CMAC_RESET = 1'b0;
        #1;
        checks++; if (bus.RX_DST_RDY !== 1'b0) begin errors++;
            $display("FAIL release_dst_rdy_early: got %b want 0", bus.RX_DST_RDY); end
        tick();
        checks++; if (bus.RX_DST_RDY !== 1'b1) begin errors++;
            $display("FAIL release_dst_rdy: got %b want 1", bus.RX_DST_RDY); end
    endtask

    task automatic test_single_words();
        logic a;
        bus.TX_RDY = 1'b1;
        idle(3);
        offer(32'hA000_0001, 4'hF, 4'h1, 4'h8, 16'h0, a);
        checks++; if (bus.TX_ENA !== 4'h0 || bus.FIFO_EMPTY !== 1'b0) begin errors++;
            $display("FAIL single_edge_k: ena=%h empty=%b, want ena=0 empty=0", bus.TX_ENA, bus.FIFO_EMPTY); end
        offer(32'hA000_0002, 4'hF, 4'h1, 4'h8, 16'h0, a);
        checks++; if (bus.TX_DATA !== make_data(32'hA000_0001) || bus.TX_ENA !== 4'hF || bus.TX_SOP !== 4'h1
                      || bus.TX_EOP !== 4'h8 || bus.TX_MTY !== 16'h0) begin errors++;
            $display("FAIL single_w1: data[31:0]=%h ena=%h sop=%h eop=%h mty=%h, want a0000001 f 1 8 0",
                     bus.TX_DATA[31:0], bus.TX_ENA, bus.TX_SOP, bus.TX_EOP, bus.TX_MTY); end
        offer(32'hA000_0003, 4'hF, 4'h1, 4'h8, 16'h0, a);
        checks++; if (bus.TX_DATA !== make_data(32'hA000_0002) || bus.TX_ENA !== 4'hF) begin errors++;
            $display("FAIL single_w2: data[31:0]=%h ena=%h, want a0000002 f", bus.TX_DATA[31:0], bus.TX_ENA); end
        idle(1);
        checks++; if (bus.TX_DATA !== make_data(32'hA000_0003) || bus.TX_ENA !== 4'hF || bus.FIFO_EMPTY !== 1'b1) begin
            errors++;
            $display("FAIL single_w3: data[31:0]=%h ena=%h empty=%b, want a0000003 f 1",
                     bus.TX_DATA[31:0], bus.TX_ENA, bus.FIFO_EMPTY); end
        idle(1);
        checks++; if (bus.TX_ENA !== 4'h0) begin errors++;
            $display("FAIL single_idle: ena=%h want 0", bus.TX_ENA); end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_fill_and_wrap();
        logic        a;
        int          acc_n;
        int          low_rdy;
        logic [31:0] tag;
        bus.TX_RDY = 1'b0;
        idle(3);
        obs_q.delete();
        exp_q.delete();
        acc_n = 0;
        for (int i = 0; i < 12; i++) begin
            offer(32'h100 + 32'(i), 4'hF, 4'h1, 4'h8, 16'(i * 3), a);
            if (a) acc_n++;
            checks++; if (bus.TX_ENA !== 4'h0) begin errors++;
                $display("FAIL fill_tx_ena[%0d]: got %h want 0", i, bus.TX_ENA); end
            if (i == 6) begin
                checks++; if (bus.RX_DST_RDY !== 1'b1) begin errors++;
                    $display("FAIL fill_dst_rdy_7: got %b want 1", bus.RX_DST_RDY); end
            end
            if (i == 7) begin
                checks++; if (bus.RX_DST_RDY !== 1'b0) begin errors++;
                    $display("FAIL fill_dst_rdy_8: got %b want 0", bus.RX_DST_RDY); end
            end
        end
        checks++; if (acc_n !== 8) begin errors++;
            $display("FAIL fill_accepted: got %0d want 8", acc_n); end
        bus.TX_RDY = 1'b1;
        tag     = 32'h108;
        acc_n   = 0;
        low_rdy = 0;
        for (int c = 0; c < 20; c++) begin
            offer(tag, 4'hF, 4'h1, 4'h8, tag[15:0], a);
            if (a) begin acc_n++; tag++; end
            if (c >= 2 && bus.RX_DST_RDY !== 1'b1) low_rdy++;
        end
        checks++; if (acc_n !== 17) begin errors++;
            $display("FAIL wrap_accepted: got %0d want 17", acc_n); end
        checks++; if (low_rdy !== 0) begin errors++;
            $display("FAIL wrap_dst_rdy: %0d cycles low, want 0", low_rdy); end
        idle(12);
        checks++; if (obs_q.size() !== 25 || exp_q.size() !== 25) begin errors++;
            $display("FAIL wrap_count: got %0d words want %0d (model %0d)", obs_q.size(), 25, exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if ({obs_q[i].data, obs_q[i].ena, obs_q[i].sop, obs_q[i].eop, obs_q[i].mty} !==
                {exp_q[i].data, exp_q[i].ena, exp_q[i].sop, exp_q[i].eop, exp_q[i].mty}) begin errors++;
                $display("FAIL wrap_word[%0d]: got data[31:0]=%h mty=%h want data[31:0]=%h mty=%h", i,
                         obs_q[i].data[31:0], obs_q[i].mty, exp_q[i].data[31:0], exp_q[i].mty); end
        end
    endtask

    task automatic test_rdy_drop();
        logic a;
        int   rej;
        logic want;
        obs_q.delete();
        exp_q.delete();
        rej = 0;
        bus.TX_RDY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            offer(32'h300 + 32'(i), 4'hF, 4'h0, 4'h0, 16'h0, a);
            if (!a) rej++;
        end
        for (int t = 1; t <= 12; t++) begin
            bus.TX_RDY = (t <= 5) ? 1'b0 : 1'b1;
            offer(32'h303 + 32'(t), 4'hF, 4'h0, 4'h0, 16'(t), a);
            if (!a) rej++;
            want = (t <= 2) || (t >= 8);
            checks++; if ((bus.TX_ENA != '0) !== want) begin errors++;
                $display("FAIL drop_tx_valid[%0d]: got %b want %b", t, (bus.TX_ENA != '0), want); end
        end
        checks++; if (rej !== 0) begin errors++;
            $display("FAIL drop_rejected: got %0d want 0", rej); end
        idle(12);
        checks++; if (obs_q.size() !== 16 || exp_q.size() !== 16) begin errors++;
            $display("FAIL drop_count: got %0d words want 16 (model %0d)", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if ({obs_q[i].data, obs_q[i].ena, obs_q[i].mty} !== {exp_q[i].data, exp_q[i].ena, exp_q[i].mty}) begin
                errors++;
                $display("FAIL drop_word[%0d]: got data[31:0]=%h want %h", i, obs_q[i].data[31:0],
                         exp_q[i].data[31:0]); end
        end
    endtask

    task automatic test_ena_zero();
        logic a;
        bus.TX_RDY = 1'b0;
        idle(3);
        obs_q.delete();
        exp_q.delete();
        for (int i = 0; i < 7; i++) offer(32'h400 + 32'(i), 4'hF, 4'h1, 4'h8, 16'h0, a);
        offer(32'hDEAD_0000, 4'h0, 4'h0, 4'h0, 16'hFFFF, a);
        checks++; if (bus.RX_DST_RDY !== 1'b1) begin errors++;
            $display("FAIL ena0_count: dst_rdy=%b want 1", bus.RX_DST_RDY); end
        offer(32'h407, 4'hF, 4'h1, 4'h8, 16'h0, a);
        checks++; if (bus.RX_DST_RDY !== 1'b0 || bus.FIFO_EMPTY !== 1'b0) begin errors++;
            $display("FAIL ena0_full: dst_rdy=%b empty=%b want 0 0", bus.RX_DST_RDY, bus.FIFO_EMPTY); end
        bus.TX_RDY = 1'b1;
        idle(12);
        checks++; if (obs_q.size() !== 8 || exp_q.size() !== 8) begin errors++;
            $display("FAIL ena0_words: got %0d words want 8 (model %0d)", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if ({obs_q[i].data, obs_q[i].ena} !== {exp_q[i].data, exp_q[i].ena}) begin errors++;
                $display("FAIL ena0_word[%0d]: got data[31:0]=%h want %h", i, obs_q[i].data[31:0],
                         exp_q[i].data[31:0]); end
        end
    endtask

    task automatic test_reset_mid_packet();
        logic a;
        bus.TX_RDY = 1'b0;
        idle(3);
        offer(32'h500, 4'hF, 4'h1, 4'h0, 16'h0, a);
        for (int i = 1; i < 5; i++) offer(32'h500 + 32'(i), 4'hF, 4'h0, 4'h0, 16'h0, a);
        bus.TX_RDY = 1'b1;
        idle(3);
        checks++; if (bus.TX_ENA !== 4'hF || bus.TX_DATA !== make_data(32'h500)) begin errors++;
            $display("FAIL mid_pre: ena=%h data[31:0]=%h want f 00000500", bus.TX_ENA, bus.TX_DATA[31:0]); end
        #2;
        CMAC_RESET = 1'b1;
        #1;
        checks++; if (bus.TX_ENA !== 4'h0 || bus.FIFO_EMPTY !== 1'b1 || bus.RX_DST_RDY !== 1'b0) begin errors++;
            $display("FAIL mid_reset: ena=%h empty=%b dst_rdy=%b want 0 1 0",
                     bus.TX_ENA, bus.FIFO_EMPTY, bus.RX_DST_RDY); end
        tick();
        tick();
        CMAC_RESET = 1'b0;
        obs_q.delete();
        exp_q.delete();
        idle(5);
        checks++; if (obs_q.size() !== 0) begin errors++;
            $display("FAIL mid_stale: got %0d words want 0", obs_q.size()); end
        offer(32'h600, 4'hF, 4'h1, 4'h8, 16'h0, a);
        offer(32'h601, 4'hF, 4'h1, 4'h8, 16'h0, a);
        idle(8);
        checks++; if (obs_q.size() !== 2 || exp_q.size() !== 2) begin errors++;
            $display("FAIL mid_new_count: got %0d words want 2 (model %0d)", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if ({obs_q[i].data, obs_q[i].sop, obs_q[i].eop} !== {exp_q[i].data, exp_q[i].sop, exp_q[i].eop}) begin
                errors++;
                $display("FAIL mid_new_word[%0d]: got data[31:0]=%h want %h", i, obs_q[i].data[31:0],
                         exp_q[i].data[31:0]); end
        end
    endtask

    initial begin
        bus.RX_DATA    = '0;
        bus.RX_ENA     = '0;
        bus.RX_SOP     = '0;
        bus.RX_EOP     = '0;
        bus.RX_MTY     = '0;
        bus.RX_SRC_RDY = 1'b0;
        bus.TX_RDY     = 1'b0;
        test_reset();
        test_single_words();
        test_fill_and_wrap();
        test_rdy_drop();
        test_ena_zero();
        test_reset_mid_packet();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog");
    end

endmodule
